// File: rtl/pe_join_pipe.sv
// pe_join_pipe: joins NUM_IN valid/ready input channels, adds one token from
// each, and carries the sum through a LATENCY-stage elastic pipeline whose
// bubbles collapse and whose back-pressure reaches the producers.
//
// Build option: define PE_JOIN_SATURATE_EN to clamp an overflowing sum to
// all-ones; without it the sum wraps modulo 2^WIDTH. Timing is identical.
module pe_join_pipe #(
  parameter int WIDTH   = 16,
  parameter int NUM_IN  = 2,
  parameter int LATENCY = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN*WIDTH-1:0]      data_in,
  input  logic [NUM_IN-1:0]            valid_in,
  output logic [NUM_IN-1:0]            ready_in,
  output logic [WIDTH-1:0]             data_out,
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic [$clog2(LATENCY+1)-1:0] occupancy
);

  localparam int SUM_W = WIDTH + $clog2(NUM_IN);
  localparam int OCC_W = $clog2(LATENCY + 1);

  // Unsigned sum of every channel, wide enough that it can never overflow.
  function automatic logic [SUM_W-1:0] sum_channels(input logic [NUM_IN*WIDTH-1:0] d);
    logic [SUM_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      acc = acc + SUM_W'(d[i*WIDTH +: WIDTH]);
    end
    return acc;
  endfunction

  // Narrow the wide sum back to WIDTH bits (clamp or wrap, by build).
  function automatic logic [WIDTH-1:0] reduce_sum(input logic [SUM_W-1:0] s);
`ifdef PE_JOIN_SATURATE_EN
    logic [SUM_W-1:0] lim;
    lim = '0;
    lim[WIDTH-1:0] = '1;
    if (s > lim) begin
      return '1;
    end else begin
      return s[WIDTH-1:0];
    end
`else
    return s[WIDTH-1:0];
`endif
  endfunction

  logic [LATENCY:1]            valid_r;
  logic [LATENCY:1][WIDTH-1:0] data_r;
  logic [LATENCY:1]            adv_s;
  logic                        fire_s;
  logic                        out_hs_s;
  logic [WIDTH-1:0]            stage1_data_s;
  logic [OCC_W-1:0]            occ_r;

  // Advance chain: a stage moves when the one below moves or when it is empty.
  // Accumulated from the output end so no signal feeds back on itself.
  always_comb begin
    logic open_v;
    adv_s  = '0;
    open_v = ready_out | ~valid_r[LATENCY];
    adv_s[LATENCY] = open_v;
    for (int k = LATENCY - 1; k >= 1; k--) begin
      open_v   = open_v | ~valid_r[k];
      adv_s[k] = open_v;
    end
  end

  // Join: fire only when every channel holds a token and stage 1 can take it;
  // nothing is consumed while reset is asserted.
  always_comb begin
    fire_s        = (&valid_in) & adv_s[1] & ~rst;
    out_hs_s      = valid_r[LATENCY] & ready_out;
    stage1_data_s = reduce_sum(sum_channels(data_in));
  end

  assign ready_in  = {NUM_IN{fire_s}};
  assign data_out  = data_r[LATENCY];
  assign valid_out = valid_r[LATENCY];
  assign occupancy = occ_r;

  // Pipeline stages: load on advance, hold otherwise; reset flushes all tokens.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
      data_r  <= '0;
    end else begin
      if (adv_s[1]) begin
        valid_r[1] <= fire_s;
        if (fire_s) begin
          data_r[1] <= stage1_data_s;
        end
      end
      for (int k = 2; k <= LATENCY; k++) begin
        if (adv_s[k]) begin
          valid_r[k] <= valid_r[k-1];
          data_r[k]  <= data_r[k-1];
        end
      end
    end
  end

  // Occupancy tracks tokens entering versus tokens leaving each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r <= '0;
    end else begin
      case ({fire_s, out_hs_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_join_pipe.sv
// Directed bench for pe_join_pipe (WIDTH=16, NUM_IN=2, LATENCY=4). Stimulus
// pushes expected sums into a queue; a negedge monitor pops and compares on
// every output handshake.
module tb_pe_join_pipe;
  localparam int WIDTH   = 16;
  localparam int NUM_IN  = 2;
  localparam int LATENCY = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_IN*WIDTH-1:0] data_in;
  logic [NUM_IN-1:0]       valid_in;
  logic [NUM_IN-1:0]       ready_in;
  logic [WIDTH-1:0]        data_out;
  logic                    valid_out;
  logic                    ready_out;
  logic [2:0]              occupancy;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  pe_join_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .ready_in(ready_in), .data_out(data_out), .valid_out(valid_out),
    .ready_out(ready_out), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] c0, input logic [15:0] c1, input logic [1:0] v);
    data_in  = {c1, c0};
    valid_in = v;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    ready_out = 1'b1;
    valid_in  = 2'b00;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d tokens left expected 0", exp_q.size());
      exp_q.delete();
    end
    tick();
    check("drain_occ", 32'(occupancy), 32'd0);
  endtask

  // Monitor: every output handshake must match the oldest expected sum.
  always @(negedge clk) begin
    if (!rst && valid_out && ready_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got %0h expected none", data_out);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL out_data: got %0h expected %0h", data_out, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct { logic [15:0] a; logic [15:0] b; logic [15:0] s; } vec_t;
  vec_t vecs[5];

  initial begin
    int nxt;
    vecs[1] = '{16'hFFFF, 16'h0000, 16'hFFFF};
    vecs[3] = '{16'h7FFF, 16'h8000, 16'hFFFF};
    vecs[4] = '{16'h1234, 16'h4321, 16'h5555};
`ifdef PE_JOIN_SATURATE_EN
    vecs[0] = '{16'hFFF0, 16'h0020, 16'hFFFF};
    vecs[2] = '{16'h8000, 16'h8000, 16'hFFFF};
`else
    vecs[0] = '{16'hFFF0, 16'h0020, 16'h0010};
    vecs[2] = '{16'h8000, 16'h8000, 16'h0000};
`endif

    // Reset state
    rst = 1'b1; valid_in = 2'b00; data_in = '0; ready_out = 1'b1;
    tick(); tick();
    valid_in = 2'b11;
    #1 check("rst_ready_in", 32'(ready_in), 32'd0);
    tick();
    rst = 1'b0; valid_in = 2'b00;
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_ready_idle", 32'(ready_in), 32'd0);
    valid_in = 2'b01;
    #1 check("rst_ready_partial", 32'(ready_in), 32'd0);

    // Basic latency
    drive(16'h0003, 16'h0005, 2'b11);
    exp_q.push_back(16'h0008);
    #1 check("lat_ready_in", 32'(ready_in), 32'd3);
    tick();
    valid_in = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      check("lat_occ", 32'(occupancy), 32'd1);
      check("lat_valid", 32'(valid_out), (i == 4) ? 32'd1 : 32'd0);
      if (i < 4) tick();
    end
    check("lat_data", 32'(data_out), 32'h0008);
    tick();
    check("lat_occ_after", 32'(occupancy), 32'd0);

    // Join wait
    drive(16'h0023, 16'h0100, 2'b01);
    for (int i = 0; i < 5; i++) begin
      #1 check("join_wait_ready", 32'(ready_in), 32'd0);
      tick();
    end
    valid_in = 2'b11;
    exp_q.push_back(16'h0123);
    #1 check("join_fire_ready", 32'(ready_in), 32'd3);
    tick();
    valid_in = 2'b00;
    check("join_occ", 32'(occupancy), 32'd1);
    drain(20);

    // Back-pressure
    ready_out = 1'b0;
    nxt = 1;
    for (int c = 0; c < 8; c++) begin
      drive(16'(nxt), 16'(nxt), 2'b11);
      #1 check("bp_ready_in", 32'(ready_in), (c < 4) ? 32'd3 : 32'd0);
      if (c < 4) begin
        exp_q.push_back(16'(2 * nxt));
        nxt++;
      end
      tick();
    end
    check("bp_occ_full", 32'(occupancy), 32'd4);
    check("bp_valid_out", 32'(valid_out), 32'd1);
    check("bp_frozen", 32'(data_out), 32'd2);
    tick();
    check("bp_frozen_later", 32'(data_out), 32'd2);
    check("bp_ready_full", 32'(ready_in), 32'd0);
    ready_out = 1'b1;
    valid_in  = 2'b00;
    for (int j = 0; j < 4; j++) begin
      #1 check("bp_stream_valid", 32'(valid_out), 32'd1);
      tick();
    end
    check("bp_empty_valid", 32'(valid_out), 32'd0);
    check("bp_empty_occ", 32'(occupancy), 32'd0);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Overflow / boundary sums, back to back
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].a, vecs[i].b, 2'b11);
      exp_q.push_back(vecs[i].s);
      #1 check("ovf_ready_in", 32'(ready_in), 32'd3);
      tick();
    end
    drain(20);

    // Mid-stream reset with three tokens in flight
    for (int i = 0; i < 3; i++) begin
      drive(16'(16'h0010 + i), 16'h0020, 2'b11);
      tick();
    end
    check("mrst_occ_before", 32'(occupancy), 32'd3);
    rst = 1'b1;
    #1 check("mrst_ready_in", 32'(ready_in), 32'd0);
    tick();
    rst = 1'b0;
    valid_in = 2'b00;
    check("mrst_valid_out", 32'(valid_out), 32'd0);
    check("mrst_occ", 32'(occupancy), 32'd0);
    check("mrst_data_out", 32'(data_out), 32'd0);
    for (int i = 0; i < 8; i++) begin
      #1 check("mrst_no_stale", 32'(valid_out), 32'd0);
      tick();
    end

    // Full pass-through
    ready_out = 1'b0;
    nxt = 100;
    for (int c = 0; c < 4; c++) begin
      drive(16'(nxt), 16'h0001, 2'b11);
      exp_q.push_back(16'(nxt + 1));
      #1 check("pt_fill_ready", 32'(ready_in), 32'd3);
      nxt++;
      tick();
    end
    check("pt_occ_full", 32'(occupancy), 32'd4);
    ready_out = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drive(16'(nxt), 16'h0001, 2'b11);
      exp_q.push_back(16'(nxt + 1));
      #1 check("pt_ready", 32'(ready_in), 32'd3);
      check("pt_occ", 32'(occupancy), 32'd4);
      nxt++;
      tick();
    end
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_join_pipe.md
# pe_join_pipe

Parametrised dataflow processing element that joins `NUM_IN` input channels, adds one token from each, and carries the sum through a `LATENCY`-stage pipeline that can stall. Each channel uses a valid/ready handshake. The block replaces fixed 1-in/1-out delay PEs in the dataflow graph. It fires only when every input holds a token, and it applies back-pressure from the consumer all the way to the producers.

## Interface
- `WIDTH`, 16: data width per channel and of the output.
- `NUM_IN`, 2: number of joined input channels, 1..8.
- `LATENCY`, 4: pipeline depth in stages, at least 1.
- `clk`  input  1  clock.
- `rst`  input  1  reset; synchronous, active-high.
- `data_in`  input  `NUM_IN*WIDTH`  packed input tokens; channel i occupies bits [i*WIDTH +: WIDTH].
- `valid_in`  input  `NUM_IN`  per-channel token valid.
- `ready_in`  output  `NUM_IN`  per-channel token consumed this cycle.
- `data_out`  output  `WIDTH`  result token.
- `valid_out`  output  1  result valid.
- `ready_out`  input  1  consumer accepts the result.
- `occupancy`  output  `$clog2(LATENCY+1)`  number of valid stages in the pipeline.

## Operation
- **Pipeline:** stages s[1..LATENCY], each holding a data register and a valid bit. `data_out` and `valid_out` come from s[LATENCY].
- **Stage advance:** `adv[LATENCY] = ready_out | ~v[LATENCY]`. For lower stages, `adv[k] = adv[k+1] | ~v[k]`. Bubbles collapse, so an empty stage always accepts.
- **Fire rule:** `fire = (&valid_in) & adv[1]`.
- **Input ready:** every bit of `ready_in` equals `fire`. A channel is never consumed alone. `ready_in` depends combinationally on `valid_in` and `ready_out`.
- **On fire:** s[1] loads the sum of all `NUM_IN` channels.
  - The sum is unsigned and accumulated at `WIDTH+$clog2(NUM_IN)` bits.
  - It is then reduced to `WIDTH` bits according to the Configuration section.
- **Stage 1 when not firing:** if `adv[1]` is high and `fire` is low, v[1] is cleared.
- **Stage k>1:** when `adv[k]` is high, s[k] loads s[k-1] (data and valid).
- **Holding:** a stage with `adv` low holds its data and valid unchanged.
- **Occupancy:** `occupancy` is a registered count of set valid bits.
  - Increments on fire without output handshake.
  - Decrements on output handshake without fire.
  - Unchanged when both or neither occur.
- **`NUM_IN=1`:** degenerates to an elastic delay line.

## Timing
- **Reset:** all v[k]=0, all data registers=0, `occupancy`=0. Therefore `valid_out`=0 and `data_out`=0, and `ready_in` is low unless every channel is valid.
- **Reset has priority:** `rst` asserted mid-stream discards all in-flight tokens that same edge. No token is consumed from the inputs during a reset cycle, so `ready_in` is forced to 0 while `rst` is high.
- **Latency:** with no stalls, a token fired in cycle n presents `valid_out`=1 in cycle n+LATENCY.
- **Throughput:** one token per cycle while `ready_out` is held high.
- **Full pipeline with `ready_out`=0:** `ready_in`=0 and `occupancy`=LATENCY. Contents are frozen and `data_out` is stable.
- **Full pipeline with `ready_out`=1 and all inputs valid:** fire and output handshake happen in the same cycle, and `occupancy` stays at LATENCY.
- **Stall release:** the cycle after `ready_out` rises, the pipeline shifts by one stage. Gaps before a stall are squeezed out.
- **Output stability:** while `valid_out`=1 and `ready_out`=0, `data_out` must not change.

## Configuration
- **Macro `PE_JOIN_SATURATE_EN`.**
  - Defined: if the wide sum exceeds 2^WIDTH−1, s[1] loads all-ones.
  - Undefined: s[1] loads the sum modulo 2^WIDTH (low `WIDTH` bits).
- All timing is identical in both builds.

## Test plan
All scenarios use `WIDTH`=16, `NUM_IN`=2, `LATENCY`=4.
- **Basic latency:** after reset, drive ch0=0x0003 and ch1=0x0005, both valid, for one cycle, with `ready_out`=1 → `ready_in`=2'b11 that cycle; `valid_out`=1 with `data_out`=0x0008 exactly 4 cycles later; `occupancy` is 1 throughout.
- **Join wait:** hold ch0 valid=1 and ch1 valid=0 for 5 cycles, then raise ch1 → `ready_in` stays 0 for all 5 cycles; exactly one fire occurs when ch1 rises; `data_out` is the sum.
- **Back-pressure:** hold `ready_out`=0 with both inputs streaming values 1,2,3,… → after 4 accepted tokens, `ready_in`=0, `occupancy`=4, and `data_out` is frozen at the first sum. Then raise `ready_out` → one token per cycle with no loss or duplication, in order.
- **Overflow:** ch0=0xFFF0, ch1=0x0020 → `data_out`=0x0010 without the macro; `data_out`=0xFFFF with `PE_JOIN_SATURATE_EN`.
- **Mid-stream reset:** with 3 tokens in flight, assert `rst` for 1 cycle → the next cycle shows `valid_out`=0, `occupancy`=0, and `data_out`=0; no stale token ever appears at the output.
- **Full pass-through:** with the pipeline full and `ready_out`=1 and inputs valid every cycle → fire every cycle, `occupancy` constant at 4, and outputs in order.
